// File: rtl/rock_pkg.sv
// Shared types and constants for the rock scheduler.
// Used by rock_scheduler and hold_timer.
package rock_pkg;
  localparam int LEVEL_W        = 3;
  localparam int HOLD_W         = 8;
  localparam int DEF_MAX_LEVEL  = 7;
  localparam int DEF_HOLD_TICKS = 8;
  localparam int DEF_FIX_FREQ   = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;
endpackage

// File: rtl/hold_timer.sv
// Hold countdown: load wins over decrement, saturates at zero.
// zero flags an expired (or never loaded) hold.
module hold_timer
  import rock_pkg::*;
#(
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] ONE    = HOLD_W'(1);

  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/rock_scheduler.sv
// Rock cycle scheduler: ramp amp up, hold, ramp down, fault on error.
// Define ROCK_FREQ_TRACK_EN to make freq follow amp instead of FIX_FREQ.
module rock_scheduler
  import rock_pkg::*;
#(
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int FIX_FREQ   = DEF_FIX_FREQ
) (
  input  logic               clk,
  input  logic               extReset,
  input  logic               slow,
  input  logic               stressTick,
  input  logic               stressLaag,
  input  logic               errorIn,
  output logic [LEVEL_W-1:0] amp,
  output logic [LEVEL_W-1:0] freq,
  output logic               busy,
  output logic               fault
);
  localparam logic [LEVEL_W-1:0] TOP = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] ONE = LEVEL_W'(1);

  state_t             state;
  state_t             state_n;
  logic [LEVEL_W-1:0] lvl;
  logic [LEVEL_W-1:0] lvl_n;
  logic [LEVEL_W-1:0] freq_n;
  logic               load;
  logic               dec;
  logic               zero;
  logic               stress_hi;

  assign stress_hi = stressTick & ~stressLaag;
  assign dec       = slow && (state == ST_HOLD);

  hold_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold (
    .clk (clk),
    .rst (extReset),
    .load(load),
    .dec (dec),
    .zero(zero)
  );

  always_comb begin
    state_n = state;
    lvl_n   = lvl;
    load    = 1'b0;
    if (errorIn) begin
      state_n = ST_FAULT;
      lvl_n   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          lvl_n = '0;
          if (stress_hi) state_n = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (slow) begin
            if (lvl >= TOP - ONE) begin
              lvl_n   = TOP;
              state_n = ST_HOLD;
              load    = 1'b1;
            end else begin
              lvl_n = lvl + ONE;
            end
          end
        end
        ST_HOLD: begin
          // expiry samples stressLaag even without a tick
          if (zero) begin
            if (stressLaag) state_n = ST_RAMP_DOWN;
            else            load    = 1'b1;
          end
          if (stress_hi) load = 1'b1;
        end
        ST_RAMP_DOWN: begin
          if (stress_hi) begin
            state_n = ST_RAMP_UP;
          end else if (slow) begin
            if (lvl <= ONE) begin
              lvl_n   = '0;
              state_n = ST_IDLE;
            end else begin
              lvl_n = lvl - ONE;
            end
          end
        end
        ST_FAULT: begin
          lvl_n = '0;
          if (slow) state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
          lvl_n   = '0;
        end
      endcase
    end
  end

`ifdef ROCK_FREQ_TRACK_EN
  assign freq_n = lvl_n;
`else
  localparam logic [LEVEL_W-1:0] FIXF = LEVEL_W'(FIX_FREQ);
  assign freq_n = (lvl_n != '0) ? FIXF : '0;
`endif

  always_ff @(posedge clk) begin
    if (extReset) begin
      state <= ST_IDLE;
      lvl   <= '0;
      freq  <= '0;
      busy  <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      lvl   <= lvl_n;
      freq  <= freq_n;
      busy  <= (state_n != ST_IDLE);
      fault <= (state_n == ST_FAULT);
    end
  end

  assign amp = lvl;
endmodule

// File: tb/tb_rock_scheduler.sv
// Scoreboard bench for rock_scheduler with default parameters.
// Expected outputs are queued by stimulus and checked by a monitor.
module tb_rock_scheduler;
  logic       clk;
  logic       extReset;
  logic       slow;
  logic       stressTick;
  logic       stressLaag;
  logic       errorIn;
  logic [2:0] amp;
  logic [2:0] freq;
  logic       busy;
  logic       fault;

  int tests;
  int fails;

  typedef struct {
    string      name;
    logic [2:0] amp;
    logic [2:0] freq;
    logic       busy;
    logic       fault;
  } exp_t;

  exp_t q[$];

  rock_scheduler dut (
    .clk       (clk),
    .extReset  (extReset),
    .slow      (slow),
    .stressTick(stressTick),
    .stressLaag(stressLaag),
    .errorIn   (errorIn),
    .amp       (amp),
    .freq      (freq),
    .busy      (busy),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ef(input logic [2:0] a);
`ifdef ROCK_FREQ_TRACK_EN
    return a;
`else
    return (a != 3'd0) ? 3'd3 : 3'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (amp !== e.amp || freq !== e.freq ||
          busy !== e.busy || fault !== e.fault) begin
        fails++;
        $display("FAIL %s: got amp=%0d freq=%0d busy=%0b fault=%0b, want amp=%0d freq=%0d busy=%0b fault=%0b",
                 e.name, amp, freq, busy, fault,
                 e.amp, e.freq, e.busy, e.fault);
      end
    end
  end

  task automatic cyc(input logic s, input logic t, input logic l,
                     input logic er, input logic r,
                     input logic [2:0] a, input logic b, input logic f,
                     input string n);
    exp_t e;
    @(negedge clk);
    slow       = s;
    stressTick = t;
    stressLaag = l;
    errorIn    = er;
    extReset   = r;
    @(posedge clk);
    #1;
    e.name  = n;
    e.amp   = a;
    e.freq  = ef(a);
    e.busy  = b;
    e.fault = f;
    q.push_back(e);
  endtask

  task automatic step(input logic l, input logic [2:0] a,
                      input logic b, input string n);
    cyc(1'b1, 1'b0, l, 1'b0, 1'b0, a, b, 1'b0, n);
    cyc(1'b0, 1'b0, l, 1'b0, 1'b0, a, b, 1'b0, n);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    extReset   = 1'b1;
    slow       = 1'b0;
    stressTick = 1'b0;
    stressLaag = 1'b1;
    errorIn    = 1'b0;

    cyc(0, 0, 1, 0, 1, 3'd0, 0, 0, "reset");
    cyc(0, 1, 1, 0, 0, 3'd0, 0, 0, "idle_low_stress");

    // full rock cycle
    cyc(0, 1, 0, 0, 0, 3'd0, 1, 0, "start");
    for (int k = 1; k <= 7; k++) step(1, 3'(k), 1, "ramp_up");
    for (int k = 0; k < 8; k++) step(1, 3'd7, 1, "hold");
    for (int k = 6; k >= 0; k--) step(1, 3'(k), k != 0, "ramp_down");
    cyc(0, 0, 1, 0, 0, 3'd0, 0, 0, "idle_after");

    // re-stress during ramp down
    cyc(0, 1, 0, 0, 0, 3'd0, 1, 0, "start2");
    for (int k = 1; k <= 7; k++) step(1, 3'(k), 1, "ramp_up2");
    for (int k = 0; k < 8; k++) step(1, 3'd7, 1, "hold2");
    step(1, 3'd6, 1, "down2");
    step(1, 3'd5, 1, "down2");
    cyc(1, 1, 0, 0, 0, 3'd5, 1, 0, "tick_in_down");
    cyc(0, 0, 0, 0, 0, 3'd5, 1, 0, "tick_in_down");
    step(0, 3'd6, 1, "reup");
    step(0, 3'd7, 1, "reup");

    // hold expiry with high stress reloads
    for (int k = 0; k < 8; k++) step(0, 3'd7, 1, "hold_hi");
    for (int k = 0; k < 8; k++) step(0, 3'd7, 1, "hold_reload");

    // reset beats error in hold
    cyc(0, 0, 1, 1, 1, 3'd0, 0, 0, "rst_err");
    cyc(0, 0, 1, 0, 0, 3'd0, 0, 0, "post_rst");

    // error mid-ramp
    cyc(0, 1, 0, 0, 0, 3'd0, 1, 0, "start3");
    for (int k = 1; k <= 4; k++) step(1, 3'(k), 1, "ramp_up3");
    cyc(0, 0, 1, 1, 0, 3'd0, 1, 1, "err");
    cyc(1, 0, 1, 1, 0, 3'd0, 1, 1, "err_slow");
    cyc(0, 1, 0, 0, 0, 3'd0, 1, 1, "fault_tick");
    cyc(0, 0, 1, 0, 0, 3'd0, 1, 1, "fault_wait");
    cyc(1, 0, 1, 0, 0, 3'd0, 0, 0, "fault_exit");

    // slow with tick in ramp up, then reset mid-ramp
    cyc(0, 1, 0, 0, 0, 3'd0, 1, 0, "start4");
    cyc(1, 1, 0, 0, 0, 3'd1, 1, 0, "up_slow_tick");
    cyc(0, 0, 1, 0, 0, 3'd1, 1, 0, "up_slow_tick");
    step(1, 3'd2, 1, "ramp_up4");
    step(1, 3'd3, 1, "ramp_up4");
    cyc(0, 0, 1, 0, 1, 3'd0, 0, 0, "rst_mid_ramp");
    cyc(0, 0, 1, 0, 0, 3'd0, 0, 0, "post_rst2");

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
